traffic_light_monitor: RTL and testbench

- Passive checker on the light outputs of the highway/country-road intersection controller; it is the consumer of the `highWay`/`countryRoad` light codes.
- Decodes the two 2-bit light codes every clock into an intersection phase and checks that the phase sequence is legal.
- Enforces yellow and all-red dwell limits and records the first fault in a sticky fault code.
- Sits beside the controller in the top level and in benches as a self-check; it never drives the lights.

---
 rtl/traffic_light_monitor.sv | 143 ++++++++++++++
 tb/tb_traffic_light_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker for the highway/country-road light controller: tracks the
// intersection phase, enforces sequence and dwell limits, latches the first fault.
module traffic_light_monitor #(
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned MAX_YELLOW = 8,
  parameter int unsigned MIN_ALLRED = 5
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] highWay,
  input  logic [1:0] countryRoad,
  output logic [2:0] phase,
  output logic [7:0] dwell,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] cycle_count
);

  typedef enum logic [2:0] {
    StSync = 3'd0,
    StHg   = 3'd1,
    StHy   = 3'd2,
    StAr   = 3'd3,
    StCg   = 3'd4,
    StCy   = 3'd5
  } phase_e;

  localparam logic [1:0] LightRed    = 2'b00;
  localparam logic [1:0] LightYellow = 2'b01;
  localparam logic [1:0] LightGreen  = 2'b10;
  localparam logic [1:0] LightBad    = 2'b11;

  localparam logic [7:0] MinYellow = 8'(MIN_YELLOW);
  localparam logic [7:0] MaxYellow = 8'(MAX_YELLOW);
  localparam logic [7:0] MinAllRed = 8'(MIN_ALLRED);

  localparam logic [2:0] CodeNone     = 3'd0;
  localparam logic [2:0] CodeEncoding = 3'd1;
  localparam logic [2:0] CodeConflict = 3'd2;
  localparam logic [2:0] CodeSequence = 3'd3;
  localparam logic [2:0] CodeYelShort = 3'd4;
  localparam logic [2:0] CodeYelLong  = 3'd5;
  localparam logic [2:0] CodeRedShort = 3'd6;

  phase_e     phase_q, phase_d;
  logic [7:0] dwell_q, dwell_d;
  logic       fault_q, fault_d;
  logic [2:0] code_q, code_d;
  logic [7:0] cycles_q, cycles_d;

  logic       bad_enc, conflict;
  phase_e     pair_phase, succ_phase;
  logic [2:0] sample_code;
  logic       in_yellow;

  always_comb begin
    pair_phase = StSync;
    bad_enc    = (highWay == LightBad) || (countryRoad == LightBad);
    conflict   = !bad_enc && (highWay != LightRed) && (countryRoad != LightRed);
    if (highWay == LightGreen && countryRoad == LightRed)       pair_phase = StHg;
    else if (highWay == LightYellow && countryRoad == LightRed) pair_phase = StHy;
    else if (highWay == LightRed && countryRoad == LightRed)    pair_phase = StAr;
    else if (highWay == LightRed && countryRoad == LightGreen)  pair_phase = StCg;
    else if (highWay == LightRed && countryRoad == LightYellow) pair_phase = StCy;
  end

  always_comb begin
    succ_phase = StSync;
    unique case (phase_q)
      StHg:    succ_phase = StHy;
      StHy:    succ_phase = StAr;
      StAr:    succ_phase = StCg;
      StCg:    succ_phase = StCy;
      StCy:    succ_phase = StHg;
      default: succ_phase = StSync;
    endcase
  end

  assign in_yellow = (phase_q == StHy) || (phase_q == StCy);

  always_comb begin
    phase_d     = phase_q;
    dwell_d     = dwell_q;
    cycles_d    = cycles_q;
    sample_code = CodeNone;

    if (bad_enc) begin
      sample_code = CodeEncoding;
    end else if (conflict) begin
      sample_code = CodeConflict;
    end else if (phase_q == StSync) begin
      if (pair_phase == StHg) begin
        phase_d = StHg;
        dwell_d = 8'd1;
      end
    end else if (pair_phase == phase_q) begin
      dwell_d = (dwell_q == 8'hff) ? dwell_q : dwell_q + 8'd1;
      // Only the sample that would push dwell past the limit flags it.
      if (in_yellow && dwell_q == MaxYellow) sample_code = CodeYelLong;
    end else if (pair_phase == succ_phase) begin
      phase_d = pair_phase;
      dwell_d = 8'd1;
      if (in_yellow && dwell_q < MinYellow)          sample_code = CodeYelShort;
      else if (phase_q == StAr && dwell_q < MinAllRed) sample_code = CodeRedShort;
      if (phase_q == StCy) cycles_d = cycles_q + 8'd1;
    end else begin
      sample_code = CodeSequence;
    end

    // Structural faults lose sync; resume on the next highway-green.
    if (sample_code == CodeEncoding || sample_code == CodeConflict ||
        sample_code == CodeSequence) begin
      phase_d = StSync;
      dwell_d = 8'd0;
    end

    fault_d = fault_q || (sample_code != CodeNone);
    code_d  = fault_q ? code_q : sample_code;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      phase_q  <= StSync;
      dwell_q  <= 8'd0;
      fault_q  <= 1'b0;
      code_q   <= CodeNone;
      cycles_q <= 8'd0;
    end else begin
      phase_q  <= phase_d;
      dwell_q  <= dwell_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      cycles_q <= cycles_d;
    end
  end

  assign phase       = phase_q;
  assign dwell       = dwell_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign cycle_count = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       clear;
  logic [1:0] highWay, countryRoad;
  logic [2:0] phase;
  logic [7:0] dwell;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] cycle_count;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] X = 2'b11;

  traffic_light_monitor #(
    .MIN_YELLOW(3),
    .MAX_YELLOW(8),
    .MIN_ALLRED(5)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .highWay    (highWay),
    .countryRoad(countryRoad),
    .phase      (phase),
    .dwell      (dwell),
    .fault      (fault),
    .fault_code (fault_code),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Drive one pair for n edges; sample 1 time unit after the last edge.
  task automatic drive(input logic [1:0] hw, input logic [1:0] cr, input int n);
    for (int i = 0; i < n; i++) begin
      highWay     = hw;
      countryRoad = cr;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    clear = 1'b1;
    drive(R, R, 1);
    clear = 1'b0;
  endtask

  initial begin
    clear = 1'b0;
    highWay = R;
    countryRoad = R;
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_phase", phase, 0);
    check("rst_dwell", dwell, 0);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_cycles", cycle_count, 0);

    // Legal walk
    drive(R, R, 2);
    check("sync_hold_phase", phase, 0);
    drive(G, R, 4);
    check("walk_hg", phase, 1);
    check("walk_hg_dwell", dwell, 4);
    drive(Y, R, 3);
    check("walk_hy", phase, 2);
    drive(R, R, 5);
    check("walk_ar", phase, 3);
    check("walk_ar_dwell", dwell, 5);
    drive(R, G, 6);
    check("walk_cg", phase, 4);
    drive(R, Y, 3);
    check("walk_cy", phase, 5);
    drive(G, R, 1);
    check("walk_back_hg", phase, 1);
    check("walk_dwell", dwell, 1);
    check("walk_cycles", cycle_count, 1);
    check("walk_fault", fault, 0);

    // Illegal encoding and resync
    do_reset();
    drive(G, R, 1);
    drive(X, R, 1);
    check("enc_fault", fault, 1);
    check("enc_code", fault_code, 1);
    check("enc_phase", phase, 0);
    drive(R, R, 3);
    check("enc_rr_phase", phase, 0);
    drive(G, R, 1);
    check("enc_resync", phase, 1);
    check("enc_code_held", fault_code, 1);

    // Yellow too short, then a later all-red-too-short does not overwrite
    do_reset();
    drive(G, R, 1);
    drive(Y, R, 2);
    check("ys_nofault_yet", fault, 0);
    drive(R, R, 1);
    check("ys_code", fault_code, 4);
    check("ys_phase", phase, 3);
    drive(R, R, 1);
    drive(R, G, 1);
    check("ys_code_held", fault_code, 4);
    check("ys_cg", phase, 4);

    // Yellow too long
    do_reset();
    drive(G, R, 1);
    drive(Y, R, 8);
    check("yl_at_max", fault, 0);
    check("yl_dwell8", dwell, 8);
    drive(Y, R, 1);
    check("yl_code", fault_code, 5);
    check("yl_dwell9", dwell, 9);
    drive(Y, R, 1);
    check("yl_dwell10", dwell, 10);
    check("yl_phase", phase, 2);

    // Illegal transition HG->AR
    do_reset();
    drive(G, R, 1);
    drive(R, R, 1);
    check("seq_code", fault_code, 3);
    check("seq_phase", phase, 0);

    // Conflict from AR
    do_reset();
    drive(G, R, 1);
    drive(Y, R, 3);
    drive(R, R, 2);
    check("cf_pre", fault, 0);
    drive(G, G, 1);
    check("cf_code", fault_code, 2);
    check("cf_phase", phase, 0);

    // All-red too short alone
    do_reset();
    drive(G, R, 1);
    drive(Y, R, 3);
    drive(R, R, 4);
    drive(R, G, 1);
    check("ar_short_code", fault_code, 6);

    // 256 legal cycles wrap cycle_count
    do_reset();
    drive(G, R, 1);
    for (int c = 0; c < 256; c++) begin
      drive(Y, R, 3);
      drive(R, R, 5);
      drive(R, G, 1);
      drive(R, Y, 3);
      drive(G, R, 1);
      if (c == 254) check("wrap_255", cycle_count, 255);
    end
    check("wrap_0", cycle_count, 0);
    check("wrap_fault", fault, 0);

    // Clear mid-HY
    drive(Y, R, 2);
    check("mid_hy", phase, 2);
    clear = 1'b1;
    drive(Y, R, 1);
    clear = 1'b0;
    check("clr_phase", phase, 0);
    check("clr_dwell", dwell, 0);
    check("clr_cycles", cycle_count, 0);

    // Dwell saturation
    drive(G, R, 300);
    check("sat_dwell", dwell, 255);
    check("sat_fault", fault, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
